// File: rtl/ifetch.sv
// Instruction fetch: one outstanding icache request at a time, static JAL
// prediction, and a small in-order instruction queue feeding the decoder.
module ifetch #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_inst,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pred_pc,
    input  logic        inst_ready,
    input  logic        flush_in,
    input  logic [31:0] flush_pc
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
    } entry_t;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d, addr_q, addr_d;
    logic          req_q, req_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   cnt_q, cnt_d;
    entry_t        mem_q [QUEUE_DEPTH];
    entry_t        head_e;
    logic          push, pop;
    logic [31:0]   jimm, next_pc;

    assign jimm    = {{12{icache_inst[31]}}, icache_inst[19:12], icache_inst[20],
                      icache_inst[30:21], 1'b0};
    assign next_pc = (icache_inst[6:0] == 7'b1101111) ? pc_q + jimm : pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (rdy_in) begin
            req_d = 1'b0;
            pop   = inst_valid && inst_ready && !flush_in;
            case (state_q)
                IDLE: if (!flush_in && cnt_q < DEPTH_C) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = WAIT;
                end
                WAIT: if (icache_valid) begin
                    state_d = IDLE;
                    if (!flush_in) begin
                        push = 1'b1;
                        pc_d = next_pc;
                    end
                end else if (flush_in) begin
                    state_d = DROP;
                end
                // A response arriving alongside a flush still retires the
                // outstanding request, otherwise DROP would wait forever.
                DROP: if (icache_valid) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (flush_in) begin
                cnt_d  = '0;
                head_d = '0;
                tail_d = '0;
                pc_d   = flush_pc;
            end else begin
                if (push) tail_d = tail_q + 1'b1;
                if (pop)  head_d = head_q + 1'b1;
                case ({push, pop})
                    2'b10:   cnt_d = cnt_q + 1'b1;
                    2'b01:   cnt_d = cnt_q - 1'b1;
                    default: cnt_d = cnt_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem_q[tail_q] <= '{inst: icache_inst, pc: pc_q, pred: next_pc};
    end

    // Head fields are forced to zero when empty so reset and drained
    // states never expose stale storage.
    assign head_e       = mem_q[head_q];
    assign inst_valid   = (cnt_q != '0);
    assign inst_out     = inst_valid ? head_e.inst : '0;
    assign inst_pc      = inst_valid ? head_e.pc   : '0;
    assign inst_pred_pc = inst_valid ? head_e.pred : '0;
    assign icache_req   = req_q && rdy_in;
    assign icache_addr  = addr_q;
endmodule
